cpu_sequencer: RTL
==================

# cpu_sequencer

Instruction-cycle controller for the accumulator CPU. It generates the one-hot FETCH/EXEC1/EXEC2 phase strobes consumed by the decoder and honours its EXTRA request. It also handles pipelined instruction overlap, halts on STP, and arbitrates the program RAM between the CPU and a debug/loader port with run/halt/single-step control. It sits between the decoder, PC/IR registers and the RAM address/write mux.

## Interface
- START_HALTED, default 0: state entered on reset (1 = HALTED, 0 = FETCH); run flag resets to !START_HALTED.
- DBG_MAX, default 64: max consecutive cycles the debug port may hold the RAM per grant (≥1).
- CNT_W, default 16: width of retired-instruction counter.

- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- IR  input  4  current opcode (STP = 4'b0111)
- EXTRA  input  1  decoder request for EXEC2, sampled in EXEC1
- PIPE_OK  input  1  decoder says final exec cycle may overlap next fetch
- dbg_req  input  1  debug port requests RAM
- dbg_run  input  1  pulse: set run flag
- dbg_halt  input  1  pulse: clear run flag
- dbg_step  input  1  pulse: execute one instruction from HALTED
- FETCH, EXEC1, EXEC2  output  1 each  one-hot phase strobes (registered)
- IR_LOAD  output  1  load IR this cycle
- dbg_gnt  output  1  debug owns RAM (registered)
- RAM_SEL  output  1  0 = CPU address/Wren, 1 = debug (equals dbg_gnt)
- HALTED  output  1  core idle (registered)
- INSTR_CNT  output  CNT_W  retired instructions, wraps

## Operation
- States: HALT, FETCH, EXEC1, EXEC2, DBG; exactly one of FETCH/EXEC1/EXEC2/HALTED/dbg_gnt high.
- FETCH → EXEC1 always.
- EXEC1: if IR==STP → HALT, run cleared, STP counted as retired. Elif EXTRA → EXEC2. Else boundary.
- EXEC2 → boundary.
- Boundary (end of final exec cycle), priority order:
  1. dbg_req && !fair_block → DBG.
  2. !run → HALT.
  3. PIPE_OK → EXEC1, with IR_LOAD high this cycle.
  4. Otherwise → FETCH.
- INSTR_CNT += 1 at every boundary and at STP.
- HALT, priority order: dbg_req → DBG; dbg_run → FETCH, run=1; dbg_step → FETCH, run stays 0, so one instruction executes and returns to HALT; else stay.
- DBG: dbg_gnt=1, CPU strobes all 0, PC/IR untouched.
  - Exit when dbg_req low, or occupancy counter reaches DBG_MAX.
  - Next state FETCH if run, else HALT.
  - Forced (DBG_MAX) exit sets fair_block; fair_block clears at the next instruction boundary, so ≥1 instruction runs before re-grant. In HALT, fair_block is ignored.
- Run flag: dbg_halt clears, dbg_run sets, dbg_halt wins if simultaneous. A cleared flag takes effect at the next boundary; an instruction in progress always completes.
- dbg_step while not in HALT: ignored.
- IR_LOAD = FETCH state OR (boundary taking the PIPE_OK path). This is the only Mealy output.

## Timing
- Reset (START_HALTED=0): FETCH=1, all other strobes 0, HALTED=0, dbg_gnt=0, IR_LOAD=1, INSTR_CNT=0, run=1, fair_block=0, occupancy=0.
- Reset (START_HALTED=1): HALTED=1, all strobes 0, IR_LOAD=0, run=0.
- Reset mid-instruction or mid-grant: abandons immediately; dbg_gnt drops the next cycle.
- Instruction lengths: 2 cycles without EXTRA, 3 with EXTRA; pipelined instructions save 1 cycle (no FETCH).
- Grant latency: dbg_gnt rises 1 cycle after the boundary or HALT cycle in which dbg_req is sampled, and falls 1 cycle after dbg_req drops.
- A forced release gives exactly DBG_MAX cycles of dbg_gnt.
- INSTR_CNT wraps from 2^CNT_W−1 to 0.
- dbg_* pulses are single-cycle. Inputs are sampled every cycle but act only in the states above.

## Test plan
- Reset, IR=LDA(0) with EXTRA=1 in EXEC1, then IR=STA(1) with EXTRA=0 → FETCH,EXEC1,EXEC2,FETCH,EXEC1,FETCH; INSTR_CNT=2.
- LSR (IR=4'hA) with PIPE_OK=1, repeated 4 times → FETCH once, then EXEC1 every cycle with IR_LOAD=1; INSTR_CNT=4 after 5 cycles.
- STP (IR=7) → HALTED=1 the next cycle and stays; dbg_step pulse → exactly one FETCH/EXEC1 pass, back to HALTED; INSTR_CNT +1.
- dbg_req held from mid-EXEC2 with DBG_MAX=4 → dbg_gnt high exactly 4 cycles after the boundary; then one full instruction; dbg_gnt re-asserts at the following boundary.
- dbg_run and dbg_halt in the same cycle during EXEC1 with EXTRA=1 → EXEC2 completes, then HALT.
- reset asserted while dbg_gnt=1 → next cycle FETCH=1, dbg_gnt=0, INSTR_CNT=0; INSTR_CNT preset near wrap (CNT_W=4, 15 instructions + 1) → reads 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction-cycle controller for the accumulator CPU.
// Generates one-hot FETCH/EXEC1/EXEC2 phase strobes, supports pipelined
// overlap of the final exec cycle with the next fetch, halts on STP, and
// arbitrates program RAM between the CPU and a debug/loader port with
// run/halt/single-step control.
//
// Parameters:
//   START_HALTED : 1 = come out of reset in HALT with run cleared, 0 = FETCH
//   DBG_MAX      : max consecutive cycles debug may hold the RAM per grant
//   CNT_W        : width of the retired-instruction counter
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   IR                    : current opcode (STP = 4'b0111)
//   EXTRA                 : decoder asks for EXEC2 (sampled in EXEC1)
//   PIPE_OK               : final exec cycle may overlap the next fetch
//   dbg_req               : debug port requests the RAM
//   dbg_run/halt/step     : single-cycle run-control pulses
//   FETCH, EXEC1, EXEC2   : registered one-hot phase strobes
//   IR_LOAD               : load IR this cycle
//   dbg_gnt, RAM_SEL      : debug owns the RAM (RAM_SEL mirrors dbg_gnt)
//   HALTED                : core idle
//   INSTR_CNT             : retired instructions, wraps
module cpu_sequencer #(
  parameter bit          START_HALTED = 1'b0,
  parameter int unsigned DBG_MAX      = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       IR,
  input  logic             EXTRA,
  input  logic             PIPE_OK,
  input  logic             dbg_req,
  input  logic             dbg_run,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic             IR_LOAD,
  output logic             dbg_gnt,
  output logic             RAM_SEL,
  output logic             HALTED,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam int unsigned OCC_W  = (DBG_MAX < 2) ? 1 : $clog2(DBG_MAX);
  localparam logic [3:0]  OP_STP = 4'b0111;

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_DBG
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_run;
  logic               r_fair_block;
  logic [OCC_W-1:0]   r_occ;
  logic [CNT_W-1:0]   r_cnt;

  logic w_stp;
  logic w_boundary;
  logic w_grant_bnd;
  logic w_pipe;
  logic w_occ_last;
  logic w_forced;

  always_comb begin
    w_stp       = (r_state == S_EXEC1) && (IR == OP_STP);
    w_boundary  = ((r_state == S_EXEC1) && !w_stp && !EXTRA) || (r_state == S_EXEC2);
    w_grant_bnd = dbg_req && !r_fair_block;
    // Pipelined path only when neither debug grant nor halt pre-empts it.
    w_pipe      = w_boundary && !w_grant_bnd && r_run && PIPE_OK;
    // r_occ counts DBG cycles already spent, so DBG_MAX-1 marks the last one.
    w_occ_last  = (r_occ == OCC_W'(DBG_MAX - 1));
    w_forced    = (r_state == S_DBG) && dbg_req && w_occ_last;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: w_next = S_EXEC1;
      S_EXEC1: begin
        if (w_stp)      w_next = S_HALT;
        else if (EXTRA) w_next = S_EXEC2;
      end
      default: ;
    endcase
    if (w_boundary) begin
      if (w_grant_bnd)  w_next = S_DBG;
      else if (!r_run)  w_next = S_HALT;
      else if (PIPE_OK) w_next = S_EXEC1;
      else              w_next = S_FETCH;
    end
    if (r_state == S_HALT) begin
      if (dbg_req)                   w_next = S_DBG;
      else if (dbg_run || dbg_step)  w_next = S_FETCH;
    end
    if (r_state == S_DBG) begin
      if (!dbg_req || w_occ_last)    w_next = r_run ? S_FETCH : S_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= START_HALTED ? S_HALT : S_FETCH;
      r_run        <= !START_HALTED;
      r_fair_block <= 1'b0;
      r_occ        <= '0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      if (w_stp || dbg_halt) r_run <= 1'b0;
      else if (dbg_run)      r_run <= 1'b1;
      if (w_forced)          r_fair_block <= 1'b1;
      else if (w_boundary)   r_fair_block <= 1'b0;
      if (r_state == S_DBG)  r_occ <= r_occ + OCC_W'(1);
      else                   r_occ <= '0;
      if (w_boundary || w_stp) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    FETCH     = (r_state == S_FETCH);
    EXEC1     = (r_state == S_EXEC1);
    EXEC2     = (r_state == S_EXEC2);
    HALTED    = (r_state == S_HALT);
    dbg_gnt   = (r_state == S_DBG);
    RAM_SEL   = dbg_gnt;
    IR_LOAD   = (r_state == S_FETCH) || w_pipe;
    INSTR_CNT = r_cnt;
  end

endmodule
